// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch bus: one-outstanding req/ready request
// channel plus an rvalid/rdata response channel.
interface if_fetch_unit_if #(
    parameter int PC_BITS   = 32,
    parameter int DATA_BITS = 32
);

    logic                 imem_req;
    logic [PC_BITS-1:0]   imem_addr;
    logic                 imem_ready;
    logic                 imem_rvalid;
    logic [DATA_BITS-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end feeding the IF/ID register.
// One fetch in flight; redirects may squash an in-flight response.
module if_fetch_unit #(
    parameter int                 PC_BITS   = 32,
    parameter int                 DATA_BITS = 32,
    parameter logic [PC_BITS-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [DATA_BITS-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    if_fetch_unit_if.master      imem,
    output logic                 if_valid,
    output logic [PC_BITS-1:0]   if_pc,
    output logic [DATA_BITS-1:0] if_instr,
    input  logic                 if_reg_write,
    input  logic                 redirect_valid,
    input  logic [PC_BITS-1:0]   redirect_pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state;
    logic [PC_BITS-1:0] pc_q;
    logic               discard_q;

    logic [PC_BITS-1:0] redir_pc;
    logic [PC_BITS-1:0] seq_pc;
    logic               accept;
    logic               beat;
    logic               consume;

    assign redir_pc = {redirect_pc[PC_BITS-1:2], 2'b00};
    assign seq_pc   = pc_q + PC_BITS'(4);
    assign accept   = (state == FETCH) && imem.imem_ready;
    assign beat     = (state == WAIT) && imem.imem_rvalid;
    assign consume  = (state == HOLD) && if_reg_write;

    // Request is a pure decode of the state; address never misaligned.
    always_comb begin
        imem.imem_req  = (state == FETCH);
        imem.imem_addr = {pc_q[PC_BITS-1:2], 2'b00};
    end

    // Fetch sequencer and IF output buffer; redirect outranks everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            if_valid  <= 1'b0;
            if_pc     <= RESET_PC;
            if_instr  <= NOP_INSTR;
        end else if (redirect_valid) begin
            pc_q     <= redir_pc;
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
            unique case (state)
                IDLE, HOLD: begin
                    state <= FETCH;
                end
                FETCH: begin
                    // Old address already taken: its response must be dropped.
                    if (accept) begin
                        state     <= WAIT;
                        discard_q <= 1'b1;
                    end else begin
                        state <= FETCH;
                    end
                end
                WAIT: begin
                    if (beat) begin
                        state     <= FETCH;
                        discard_q <= 1'b0;
                    end else begin
                        state     <= WAIT;
                        discard_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end else begin
            unique case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (accept) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (beat) begin
                        if (discard_q) begin
                            discard_q <= 1'b0;
                            state     <= FETCH;
                        end else begin
                            if_instr <= imem.imem_rdata;
                            if_pc    <= pc_q;
                            if_valid <= 1'b1;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (consume) begin
                        if_valid <= 1'b0;
                        if_instr <= NOP_INSTR;
                        pc_q     <= seq_pc;
                        state    <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end that produces the `pc`/`instr` pair loaded into the IF/ID pipeline register. It issues one word-fetch at a time to instruction memory over a req/ready + rvalid handshake. It holds each fetched instruction until the hazard unit's register-write enable accepts it. It handles branch/jump redirects, including discarding an in-flight fetch.

## Interface
- `PC_BITS`, 32, program-counter width
- `DATA_BITS`, 32, instruction word width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP_INSTR`, 32'h0000_0013, value driven on `if_instr` while no valid instruction is held

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `imem_req` out 1: fetch request, held until accepted.
- `imem_addr` out PC_BITS: fetch address; bits[1:0] always 0.
- `imem_ready` in 1: memory accepts the request in any cycle where `imem_req & imem_ready`.
- `imem_rvalid` in 1: read data valid.
- `imem_rdata` in DATA_BITS: fetched word.
- `if_valid` out 1: `if_pc`/`if_instr` hold a valid instruction.
- `if_pc` out PC_BITS: address of the held instruction.
- `if_instr` out DATA_BITS: held instruction, or `NOP_INSTR` when invalid.
- `if_reg_write` in 1: IF/ID register write enable; consumes the held instruction when `if_valid`=1.
- `redirect_valid` in 1: taken branch/jump/exception redirect.
- `redirect_pc` in PC_BITS: redirect target; bits[1:0] are ignored and forced to 0.

## Operation
- Registers:
  - `pc_q`: next fetch address.
  - `state`: IDLE, FETCH, WAIT or HOLD.
  - `discard_q`: drop the next rvalid beat.
  - Output buffer: `if_pc`, `if_instr`, `if_valid`.
- Reset values: `state`=IDLE, `pc_q`=RESET_PC, `discard_q`=0, `imem_req`=0, `imem_addr`=RESET_PC, `if_valid`=0, `if_pc`=RESET_PC, `if_instr`=NOP_INSTR.
- `imem_req` and `imem_addr` are combinational from the state: `imem_req`=1 only in FETCH; `imem_addr`=`pc_q`.
- State transitions when `redirect_valid`=0:
  - IDLE → FETCH unconditionally (one cycle after reset release).
  - FETCH: if `imem_ready`, → WAIT; else stay with `imem_req` held high and address stable.
  - WAIT with `imem_rvalid` and `discard_q`=0: latch `if_instr`=`imem_rdata`, `if_pc`=`pc_q`, `if_valid`=1; → HOLD.
  - WAIT with `imem_rvalid` and `discard_q`=1: clear `discard_q`; → FETCH.
  - HOLD with `if_reg_write`=1: `if_valid`=0, `if_instr`=NOP_INSTR, `pc_q`=`pc_q`+4 (mod 2^PC_BITS, wraps silently); → FETCH.
  - HOLD with `if_reg_write`=0: hold all outputs.
- Redirect (`redirect_valid`=1) has priority over every other event. In all cases `pc_q`=`redirect_pc`&~3, `if_valid`=0 and `if_instr`=NOP_INSTR. Per state:
  - IDLE or HOLD → FETCH. A simultaneous `if_reg_write` is ignored; the instruction is not advanced past, and the pipeline flush clears IF/ID.
  - FETCH without `imem_ready` → FETCH; the new address is presented the next cycle.
  - FETCH with `imem_ready` → WAIT with `discard_q`=1, because the old address was accepted.
  - WAIT without `imem_rvalid` → WAIT with `discard_q`=1.
  - WAIT with `imem_rvalid` → FETCH; the data is dropped and `discard_q`=0.
- Only one request is outstanding at a time; `imem_rvalid` outside WAIT is ignored.
- `if_reg_write` while `if_valid`=0 has no effect.

## Timing
- Minimum fetch-to-valid latency: request accepted in cycle N, `imem_rvalid` in N+1, `if_valid`=1 in N+2.
- Peak throughput: one instruction per 3 cycles (FETCH, WAIT, HOLD), with zero-wait memory and `if_reg_write` tied high.
- First `imem_req` rises in the 2nd cycle after `rst` deasserts.
- Redirect takes effect on the next clock edge: `if_valid` falls, and `imem_addr` shows the target in the following cycle in FETCH.
- Asserting `rst` mid-operation returns all outputs to reset values immediately. Any in-flight `imem_rvalid` after reset release is ignored, since the block is in IDLE or FETCH.

## Test plan
- Reset release, memory with 0 wait states returning `rdata`=addr^32'hA5A5_A5A5, `if_reg_write`=1 → fetches at 0x0, 0x4, 0x8. Each instruction appears with the matching `if_pc`, and `if_valid` pulses every 3 cycles.
- Hold `imem_ready`=0 for 5 cycles in FETCH → `imem_req`=1 and `imem_addr`=0x0 stable throughout; accepted on the 6th cycle.
- `if_reg_write`=0 for 4 cycles while in HOLD with `if_pc`=0x4 → outputs unchanged and no `imem_req`. Releasing it → next fetch at 0x8.
- Redirect to 0x100 while in WAIT for 0x8, rvalid 3 cycles later → the 0x8 data is never presented (`if_valid` stays 0). The next fetch is at 0x100 and `if_pc`=0x100.
- Redirect to 0x203 coincident with `imem_rvalid` in WAIT → data dropped, next `imem_addr`=0x200. Redirect in HOLD with `if_reg_write`=1 → next fetch at the target, not `pc`+4.
- Set `pc_q`=0xFFFF_FFFC by redirect, then accept the instruction → next fetch address wraps to 0x0. Assert `rst` during WAIT → outputs return to reset values and the next rvalid is ignored.
